bus_arbiter4: RTL and testbench

Round-robin arbiter that shares one `BUS_WIDTH`-bit datapath between four requesters. It grants ownership to one requester at a time and drives the select of an internal `mux4` from the multiplexing library, so the owner's data reaches the shared output. It also presents that data to a downstream consumer over a valid/ready handshake. It sits in front of any shared CPU resource fed by more than one source, such as the register-file write port or the memory address bus.

---
 rtl/bus_arbiter4_if.sv | 29 ++
 rtl/bus_arbiter4.sv | 130 +++++++++++++
 tb/tb_bus_arbiter4.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/bus_arbiter4_if.sv
// bus_arbiter4_if: bundles the four requester inputs, the downstream handshake and the grant outputs.
// Latency: none (wires only).
// Backpressure: carries out_ready from the consumer; the arbiter side decides stalls.
// Ports/signals: req[3:0], data_in0..3, out_ready (into arbiter); grant, sel, out_data, out_valid (out of arbiter).
// slave modport is the arbiter's view, master modport is the requester/consumer view.
interface bus_arbiter4_if #(
    parameter int BUS_WIDTH = 8
);
    logic [3:0]           req;
    logic [BUS_WIDTH-1:0] data_in0;
    logic [BUS_WIDTH-1:0] data_in1;
    logic [BUS_WIDTH-1:0] data_in2;
    logic [BUS_WIDTH-1:0] data_in3;
    logic                 out_ready;
    logic [3:0]           grant;
    logic [1:0]           sel;
    logic [BUS_WIDTH-1:0] out_data;
    logic                 out_valid;

    modport slave (
        input  req, data_in0, data_in1, data_in2, data_in3, out_ready,
        output grant, sel, out_data, out_valid
    );

    modport master (
        output req, data_in0, data_in1, data_in2, data_in3, out_ready,
        input  grant, sel, out_data, out_valid
    );
endinterface

// File: rtl/bus_arbiter4.sv
// bus_arbiter4: round-robin arbiter sharing one BUS_WIDTH datapath between four requesters via a mux4.
// Latency: grant/sel registered one cycle after req while idle; out_data/out_valid combinational from sel.
// Backpressure: out_ready low stalls the owner (grant and beat count hold); release on req drop or MAX_HOLD beats.
// Ports: clk, reset (sync, active high); bus.slave carries req/data_in0..3/out_ready in and
//        grant/sel/out_data/out_valid out. Exactly one idle cycle separates consecutive grants.

// Plain 4:1 multiplexer, purely combinational.
module mux4 #(
    parameter int W = 8
) (
    input  logic [1:0]   sel_i,
    input  logic [W-1:0] d0_i,
    input  logic [W-1:0] d1_i,
    input  logic [W-1:0] d2_i,
    input  logic [W-1:0] d3_i,
    output logic [W-1:0] y_o
);
    always_comb begin
        case (sel_i)
            2'd0:    y_o = d0_i;
            2'd1:    y_o = d1_i;
            2'd2:    y_o = d2_i;
            default: y_o = d3_i;
        endcase
    end
endmodule

module bus_arbiter4 #(
    parameter int BUS_WIDTH = 8,
    parameter int MAX_HOLD  = 4
) (
    input  logic              clk,
    input  logic              reset,
    bus_arbiter4_if.slave     bus
);
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] OWNED = 1'b1;
    localparam logic [3:0] HOLD  = 4'(MAX_HOLD);

    logic [0:0] state_q, state_d;
    logic [3:0] grant_q, grant_d;
    logic [1:0] sel_q,   sel_d;
    logic [1:0] last_q,  last_d;
    logic [3:0] beats_q, beats_d;

    logic [1:0] winner;
    logic [1:0] idx;
    logic       found;
    logic       owner_req;
    logic       valid;
    logic       xfer;
    logic       rel;

    // Rotating priority: scan last+1, last+2, last+3, last; first set bit wins.
    always_comb begin
        winner = last_q;
        idx    = last_q;
        found  = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            idx = last_q + 2'(k);
            if (!found && bus.req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    assign owner_req = bus.req[sel_q];
    assign valid     = (state_q == OWNED) && owner_req;
    assign xfer      = valid && bus.out_ready;
    // Either the owner withdrew, or this transfer is its last permitted beat.
    assign rel       = !owner_req || (xfer && ((beats_q + 4'd1) == HOLD));

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        sel_d   = sel_q;
        last_d  = last_q;
        beats_d = beats_q;
        case (state_q)
            IDLE: begin
                if (|bus.req) begin
                    state_d = OWNED;
                    grant_d = 4'b0001 << winner;
                    sel_d   = winner;
                    last_d  = winner;
                    beats_d = 4'd0;
                end
            end
            default: begin
                if (rel) begin
                    // sel and last keep the released owner; the next grant rotates from it.
                    state_d = IDLE;
                    grant_d = 4'b0000;
                end else if (xfer) begin
                    beats_d = beats_q + 4'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= 4'b0000;
            sel_q   <= 2'd0;
            last_q  <= 2'd3;
            beats_q <= 4'd0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            beats_q <= beats_d;
        end
    end

    assign bus.grant     = grant_q;
    assign bus.sel       = sel_q;
    assign bus.out_valid = valid;

    mux4 #(.W(BUS_WIDTH)) u_mux (
        .sel_i (sel_q),
        .d0_i  (bus.data_in0),
        .d1_i  (bus.data_in1),
        .d2_i  (bus.data_in2),
        .d3_i  (bus.data_in3),
        .y_o   (bus.out_data)
    );
endmodule

// File: tb/tb_bus_arbiter4.sv
// tb_bus_arbiter4: drives two arbiters (MAX_HOLD 4 and 1) with identical stimulus.
// Latency: checks each cycle against a behavioural model; transfers popped from per-DUT beat queues.
// Backpressure: out_ready pattern chosen per test.
module tb_bus_arbiter4;
    localparam int W = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    bus_arbiter4_if #(.BUS_WIDTH(W)) bif0 ();
    bus_arbiter4_if #(.BUS_WIDTH(W)) bif1 ();

    bus_arbiter4 #(.BUS_WIDTH(W), .MAX_HOLD(4)) u_dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bif0.slave)
    );

    bus_arbiter4 #(.BUS_WIDTH(W), .MAX_HOLD(1)) u_dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bif1.slave)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model state, one slot per DUT.
    int         hold [2] = '{4, 1};
    logic       m_own   [2];
    logic [1:0] m_owner [2];
    logic [1:0] m_last  [2];
    int         m_beats [2];

    int q0 [$];
    int q1 [$];
    bit sb_en [2];

    logic [W-1:0] dat [4];
    bit           rand_dat;
    logic [3:0]   cur_req;
    logic         cur_rdy;
    logic         cur_rst;

    task automatic model_reset(input int d);
        m_own[d]   = 1'b0;
        m_owner[d] = 2'd0;
        m_last[d]  = 2'd3;
        m_beats[d] = 0;
    endtask

    task automatic model_update(input int d);
        int c;
        logic v;
        if (cur_rst) begin
            model_reset(d);
        end else if (!m_own[d]) begin
            for (int k = 1; k <= 4; k++) begin
                c = (int'(m_last[d]) + k) % 4;
                if (!m_own[d] && cur_req[c]) begin
                    m_own[d]   = 1'b1;
                    m_owner[d] = 2'(c);
                    m_last[d]  = 2'(c);
                    m_beats[d] = 0;
                end
            end
        end else begin
            v = cur_req[m_owner[d]];
            if (!v) begin
                m_own[d] = 1'b0;
            end else if (cur_rdy) begin
                m_beats[d]++;
                if (m_beats[d] == hold[d]) m_own[d] = 1'b0;
            end
        end
    endtask

    task automatic check_dut(input int d, input logic [3:0] g, input logic [1:0] s,
                             input logic v, input logic [W-1:0] od);
        logic [3:0] exp_g;
        logic       exp_v;
        int         exp_owner;
        exp_g = m_own[d] ? (4'b0001 << m_owner[d]) : 4'b0000;
        exp_v = m_own[d] && cur_req[m_owner[d]];
        chk("grant", 32'(g), 32'(exp_g));
        chk("sel", 32'(s), 32'(m_owner[d]));
        chk("out_valid", 32'(v), 32'(exp_v));
        chk("grant_onehot0", 32'($countones(g) <= 1), 32'd1);
        chk("out_data", 32'(od), 32'(dat[m_owner[d]]));
        if (v === 1'b1 && cur_rdy && sb_en[d]) begin
            exp_owner = 4;
            if (d == 0 && q0.size() > 0) exp_owner = q0.pop_front();
            if (d == 1 && q1.size() > 0) exp_owner = q1.pop_front();
            chk("beat_owner", 32'(s), 32'(exp_owner));
            if (exp_owner < 4) chk("beat_data", 32'(od), 32'(dat[exp_owner]));
        end
    endtask

    task automatic drive_all();
        bif0.req = cur_req;  bif1.req = cur_req;
        bif0.out_ready = cur_rdy;  bif1.out_ready = cur_rdy;
        bif0.data_in0 = dat[0];  bif1.data_in0 = dat[0];
        bif0.data_in1 = dat[1];  bif1.data_in1 = dat[1];
        bif0.data_in2 = dat[2];  bif1.data_in2 = dat[2];
        bif0.data_in3 = dat[3];  bif1.data_in3 = dat[3];
        reset = cur_rst;
    endtask

    // One clock cycle: drive on the falling edge, check before the rising edge, advance the model.
    task automatic step(input logic [3:0] r, input logic rdy, input logic rst);
        @(negedge clk);
        cur_req = r;
        cur_rdy = rdy;
        cur_rst = rst;
        if (rand_dat) begin
            for (int k = 0; k < 4; k++) dat[k] = W'($urandom);
        end
        drive_all();
        #1;
        check_dut(0, bif0.grant, bif0.sel, bif0.out_valid, bif0.out_data);
        check_dut(1, bif1.grant, bif1.sel, bif1.out_valid, bif1.out_data);
        model_update(0);
        model_update(1);
    endtask

    task automatic push0(input int owner, input int n);
        for (int i = 0; i < n; i++) q0.push_back(owner);
    endtask

    initial begin
        model_reset(0);
        model_reset(1);
        sb_en[0] = 1'b1;
        sb_en[1] = 1'b0;
        rand_dat = 1'b0;
        for (int k = 0; k < 4; k++) dat[k] = W'(k);
        cur_req = 4'b0000;
        cur_rdy = 1'b0;
        cur_rst = 1'b1;
        drive_all();
        repeat (2) @(posedge clk);

        // Reset state observed while reset is still held.
        step(4'b0000, 1'b1, 1'b1);

        // Full contention, data_inK = K: rotation 0,1,2,3,0 with four beats each.
        push0(0, 4); push0(1, 4); push0(2, 4); push0(3, 4); push0(0, 4);
        for (int i = 0; i < 25; i++) step(4'b1111, 1'b1, 1'b0);

        // Sole requester 2 with out_ready toggling, re-granted after its release.
        rand_dat = 1'b1;
        push0(2, 8);
        for (int i = 0; i < 17; i++) step(4'b0100, (i % 2) == 0, 1'b0);

        // Park last on 0, then owner 1 drops req after two beats while 3 waits.
        push0(0, 4);
        for (int i = 0; i < 5; i++) step(4'b0001, 1'b1, 1'b0);
        push0(1, 2);
        for (int i = 0; i < 3; i++) step(4'b1010, 1'b1, 1'b0);
        step(4'b1000, 1'b1, 1'b0);
        step(4'b1000, 1'b1, 1'b0);
        push0(3, 4);
        for (int i = 0; i < 4; i++) step(4'b1000, 1'b1, 1'b0);

        // Reset pulsed during owner 2's third beat, then requester 0 wins first.
        push0(2, 3);
        for (int i = 0; i < 3; i++) step(4'b0100, 1'b1, 1'b0);
        step(4'b0100, 1'b1, 1'b1);
        push0(0, 4);
        for (int i = 0; i < 5; i++) step(4'b1111, 1'b1, 1'b0);

        // MAX_HOLD = 1 instance: 1,3,1,3 with single beats.
        sb_en[0] = 1'b0;
        sb_en[1] = 1'b1;
        step(4'b0000, 1'b1, 1'b1);
        q1.push_back(1); q1.push_back(3); q1.push_back(1); q1.push_back(3);
        for (int i = 0; i < 8; i++) step(4'b1010, 1'b1, 1'b0);
        step(4'b0000, 1'b0, 1'b0);

        chk("beats_left_dut0", 32'(q0.size()), 32'd0);
        chk("beats_left_dut1", 32'(q1.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
